// File: rtl/serdes_pkg.sv
// rtl/serdes_pkg.sv - shared segment serdes types and parameter helpers
package serdes_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    ASSEMBLE = 1'b1
  } asm_state_e;

  function automatic int num_segments(input int in_w, input int out_w);
    return out_w / in_w;
  endfunction

  // Legal when the word splits into a power-of-two count (>= 2) of whole segments.
  function automatic bit params_ok(input int in_w, input int out_w);
    int ns;
    if (in_w <= 0 || out_w <= 0 || (out_w % in_w) != 0) return 1'b0;
    ns = num_segments(in_w, out_w);
    return (ns >= 2) && ((ns & (ns - 1)) == 0);
  endfunction

endpackage

// File: rtl/deserializer.sv
// rtl/deserializer.sv - reassembles lowest-first narrow segments into wide words
module deserializer
  import serdes_pkg::*;
#(
  parameter int in_bit_width  = 32,
  parameter int out_bit_width = 512
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     data_valid,
  input  logic [in_bit_width-1:0]  data_in,
  output logic                     data_ready,
  input  logic                     read_data,
  output logic [out_bit_width-1:0] data_out,
  output logic                     overflow
);

  localparam int NS = num_segments(in_bit_width, out_bit_width);
  localparam int CW = $clog2(NS);
  localparam int AW = out_bit_width - in_bit_width;

  if (!params_ok(in_bit_width, out_bit_width)) begin : g_bad_params
    $error("deserializer: out_bit_width/in_bit_width must be a power of two >= 2");
  end

  asm_state_e                state_q, state_d;
  logic [CW-1:0]             seg_cnt_q, seg_cnt_d;
  logic [AW-1:0]             asm_q, asm_d;
  logic                      full_q, full_d;
  logic [out_bit_width-1:0]  dout_q, dout_d;
  logic                      ovf_q, ovf_d;
  logic                      complete;
  logic [out_bit_width-1:0]  word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      seg_cnt_q <= '0;
      asm_q     <= '0;
      full_q    <= 1'b0;
      dout_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      seg_cnt_q <= seg_cnt_d;
      asm_q     <= asm_d;
      full_q    <= full_d;
      dout_q    <= dout_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    complete  = data_valid && (seg_cnt_q == '1);
    // Top segment bypasses the assembly register so the word lands with no extra cycle.
    word      = {data_in, asm_q};
    seg_cnt_d = seg_cnt_q;
    asm_d     = asm_q;
    state_d   = state_q;
    full_d    = full_q;
    dout_d    = dout_q;
    ovf_d     = ovf_q;

    if (data_valid) begin
      seg_cnt_d = seg_cnt_q + CW'(1);
      if (!complete) asm_d[int'(seg_cnt_q)*in_bit_width +: in_bit_width] = data_in;
    end

    case (state_q)
      IDLE:     if (data_valid) state_d = ASSEMBLE;
      ASSEMBLE: if (!data_valid && seg_cnt_q == '0) state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    if (complete) begin
      if (!full_q || read_data) begin
        dout_d = word;
        full_d = 1'b1;
      end else begin
        ovf_d  = 1'b1;
      end
    end else if (read_data && full_q) begin
      full_d = 1'b0;
    end
  end

  assign data_ready = full_q;
  assign data_out   = dout_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_deserializer.sv
// tb/tb_deserializer.sv - self-checking bench for deserializer (4 x 32-bit segments)
module tb_deserializer;

  logic         clk;
  logic         reset;
  logic         data_valid;
  logic [31:0]  data_in;
  logic         data_ready;
  logic         read_data;
  logic [127:0] data_out;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  // Reference model: segment queue plus held-word state
  logic [31:0]  mq[$];
  logic         m_full;
  logic [127:0] m_out;
  logic         m_ovf;

  typedef struct {
    logic         v;
    logic [31:0]  d;
    logic         rd;
    logic         exp_ready;
    logic [127:0] exp_out;
    logic         exp_ovf;
  } vec_t;

  vec_t vec[25];

  deserializer #(.in_bit_width(32), .out_bit_width(128)) dut (
    .clk(clk), .reset(reset), .data_valid(data_valid), .data_in(data_in),
    .data_ready(data_ready), .read_data(read_data), .data_out(data_out),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_full = 1'b0;
    m_out  = '0;
    m_ovf  = 1'b0;
  endtask

  task automatic model_edge(input logic v, input logic [31:0] d, input logic rd);
    logic [127:0] w;
    logic         done;
    done = 1'b0;
    w    = '0;
    if (v) begin
      mq.push_back(d);
      if (mq.size() == 4) begin
        w    = {mq[3], mq[2], mq[1], mq[0]};
        done = 1'b1;
        mq.delete();
      end
    end
    if (done) begin
      if (!m_full || rd) begin
        m_out  = w;
        m_full = 1'b1;
      end else begin
        m_ovf  = 1'b1;
      end
    end else if (rd && m_full) begin
      m_full = 1'b0;
    end
  endtask

  // Called at a negedge: drive, clock, update model, compare at the next negedge.
  task automatic step(input logic v, input logic [31:0] d, input logic rd);
    data_valid = v;
    data_in    = d;
    read_data  = rd;
    @(posedge clk);
    model_edge(v, d, rd);
    @(negedge clk);
    chk("model_ready", {127'b0, data_ready}, {127'b0, m_full});
    chk("model_out", data_out, m_out);
    chk("model_ovf", {127'b0, overflow}, {127'b0, m_ovf});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    vec[0]  = '{1'b1, 32'h11111111, 1'b0, 1'b0, 128'h0, 1'b0};
    vec[1]  = '{1'b1, 32'h22222222, 1'b0, 1'b0, 128'h0, 1'b0};
    vec[2]  = '{1'b1, 32'h33333333, 1'b0, 1'b0, 128'h0, 1'b0};
    vec[3]  = '{1'b1, 32'h44444444, 1'b0, 1'b1, 128'h44444444_33333333_22222222_11111111, 1'b0};
    vec[4]  = '{1'b0, 32'h0,        1'b1, 1'b0, 128'h44444444_33333333_22222222_11111111, 1'b0};
    vec[5]  = '{1'b1, 32'h55555555, 1'b0, 1'b0, 128'h44444444_33333333_22222222_11111111, 1'b0};
    vec[6]  = '{1'b1, 32'h66666666, 1'b0, 1'b0, 128'h44444444_33333333_22222222_11111111, 1'b0};
    vec[7]  = '{1'b0, 32'hdeadbeef, 1'b0, 1'b0, 128'h44444444_33333333_22222222_11111111, 1'b0};
    vec[8]  = '{1'b0, 32'hdeadbeef, 1'b1, 1'b0, 128'h44444444_33333333_22222222_11111111, 1'b0};
    vec[9]  = '{1'b0, 32'hdeadbeef, 1'b0, 1'b0, 128'h44444444_33333333_22222222_11111111, 1'b0};
    vec[10] = '{1'b1, 32'h77777777, 1'b0, 1'b0, 128'h44444444_33333333_22222222_11111111, 1'b0};
    vec[11] = '{1'b1, 32'h88888888, 1'b0, 1'b1, 128'h88888888_77777777_66666666_55555555, 1'b0};
    vec[12] = '{1'b1, 32'haaaaaaaa, 1'b0, 1'b1, 128'h88888888_77777777_66666666_55555555, 1'b0};
    vec[13] = '{1'b1, 32'hbbbbbbbb, 1'b0, 1'b1, 128'h88888888_77777777_66666666_55555555, 1'b0};
    vec[14] = '{1'b1, 32'hcccccccc, 1'b0, 1'b1, 128'h88888888_77777777_66666666_55555555, 1'b0};
    vec[15] = '{1'b1, 32'hdddddddd, 1'b0, 1'b1, 128'h88888888_77777777_66666666_55555555, 1'b1};
    vec[16] = '{1'b0, 32'h0,        1'b1, 1'b0, 128'h88888888_77777777_66666666_55555555, 1'b1};
    vec[17] = '{1'b1, 32'h01010101, 1'b0, 1'b0, 128'h88888888_77777777_66666666_55555555, 1'b1};
    vec[18] = '{1'b1, 32'h02020202, 1'b0, 1'b0, 128'h88888888_77777777_66666666_55555555, 1'b1};
    vec[19] = '{1'b1, 32'h03030303, 1'b0, 1'b0, 128'h88888888_77777777_66666666_55555555, 1'b1};
    vec[20] = '{1'b1, 32'h04040404, 1'b0, 1'b1, 128'h04040404_03030303_02020202_01010101, 1'b1};
    vec[21] = '{1'b1, 32'h05050505, 1'b0, 1'b1, 128'h04040404_03030303_02020202_01010101, 1'b1};
    vec[22] = '{1'b1, 32'h06060606, 1'b0, 1'b1, 128'h04040404_03030303_02020202_01010101, 1'b1};
    vec[23] = '{1'b1, 32'h07070707, 1'b0, 1'b1, 128'h04040404_03030303_02020202_01010101, 1'b1};
    vec[24] = '{1'b1, 32'h08080808, 1'b1, 1'b1, 128'h08080808_07070707_06060606_05050505, 1'b1};

    reset      = 1'b1;
    data_valid = 1'b0;
    data_in    = '0;
    read_data  = 1'b0;
    model_reset();
    @(negedge clk);
    chk("reset_ready", {127'b0, data_ready}, 128'h0);
    chk("reset_out", data_out, 128'h0);
    chk("reset_ovf", {127'b0, overflow}, 128'h0);
    do_reset();

    for (int i = 0; i < 20; i++) begin
      step(1'b0, 32'h0, 1'b0);
      chk("idle_ready", {127'b0, data_ready}, 128'h0);
      chk("idle_out", data_out, 128'h0);
      chk("idle_ovf", {127'b0, overflow}, 128'h0);
    end

    foreach (vec[i]) begin
      step(vec[i].v, vec[i].d, vec[i].rd);
      chk($sformatf("vec%0d_ready", i), {127'b0, data_ready}, {127'b0, vec[i].exp_ready});
      chk($sformatf("vec%0d_out", i), data_out, vec[i].exp_out);
      chk($sformatf("vec%0d_ovf", i), {127'b0, overflow}, {127'b0, vec[i].exp_ovf});
    end

    // Back-to-back stream, consumer always popping
    do_reset();
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 32'h1000_0000 + 32'(i), 1'b1);
      chk("b2b_ready", {127'b0, data_ready}, {127'b0, (i % 4) == 3});
      if ((i % 4) == 3)
        chk("b2b_word", data_out,
            {32'h1000_0000 + 32'(i), 32'h1000_0000 + 32'(i - 1),
             32'h1000_0000 + 32'(i - 2), 32'h1000_0000 + 32'(i - 3)});
    end
    chk("b2b_ovf", {127'b0, overflow}, 128'h0);

    // Held word and half a word, then reset between edges
    step(1'b1, 32'ha0, 1'b0);
    step(1'b1, 32'ha1, 1'b0);
    step(1'b1, 32'ha2, 1'b0);
    step(1'b1, 32'ha3, 1'b0);
    step(1'b1, 32'hb0, 1'b0);
    step(1'b1, 32'hb1, 1'b0);
    data_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async_ready", {127'b0, data_ready}, 128'h0);
    chk("async_out", data_out, 128'h0);
    chk("async_ovf", {127'b0, overflow}, 128'h0);
    #1 reset = 1'b0;
    model_reset();
    step(1'b1, 32'hc0, 1'b0);
    step(1'b1, 32'hc1, 1'b0);
    step(1'b1, 32'hc2, 1'b0);
    step(1'b1, 32'hc3, 1'b0);
    chk("realign_ready", {127'b0, data_ready}, 128'h1);
    chk("realign_word", data_out, {32'hc3, 32'hc2, 32'hc1, 32'hc0});

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 4) == 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/deserializer.md
# deserializer

Receive-side counterpart of the segment serializer: accepts a stream of narrow segments (lowest segment first) and reassembles them into full-width parallel words. The output register and assembly register are separate, so the upstream stream never stalls while a finished word waits for the consumer. The block sits at the link receive edge, feeding the wide datapath through a show-ahead valid/pop handshake.

## Interface
Parameters:
- `in_bit_width`, default 32: segment width.
- `out_bit_width`, default 512: reassembled word width.
- Constraint: `out_bit_width / in_bit_width` (num_segments) must be a power of two and ≥ 2.

Ports:
- `clk`  input  1  sole clock; all state on its rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state immediately.
- `data_valid`  input  1  upstream strobe: `data_in` carries a valid segment this cycle.
- `data_in`  input  in_bit_width  incoming segment.
- `data_ready`  output  1  `data_out` holds a complete word.
- `read_data`  input  1  consumer pop; effective only while `data_ready`=1.
- `data_out`  output  out_bit_width  completed word, stable while `data_ready`=1.
- `overflow`  output  1  sticky: a completed word was dropped.

## Operation
- Segment counter `seg_counter`, width $clog2(num_segments), reset 0. Each cycle with `data_valid`=1, `data_in` is written to assembly slice `[in_bit_width*(seg_counter+1)-1 : in_bit_width*seg_counter]` and the counter increments. It wraps from all-ones to 0.
- Assembly FSM, with states in the shared enum:
  - IDLE: counter = 0. `data_valid` goes to ASSEMBLE.
  - ASSEMBLE: completion occurs on `data_valid` while the counter is all-ones. At completion, go to IDLE if `data_valid` is not held the next cycle; back-to-back segments stay in ASSEMBLE.
- Completed word = current `data_in` in the top slice plus the lower assembly slices. It is forwarded directly, so there is no extra cycle.
- Output holding register, EMPTY/FULL (`data_ready` = FULL):
  - Completion while EMPTY: load the word and set FULL.
  - `read_data` while FULL with no completion: set EMPTY.
  - Completion and `read_data` in the same cycle while FULL: load the new word and stay FULL.
  - Completion while FULL without `read_data`: drop the new word, keep the held word, and set `overflow`=1. `overflow` clears only on reset.
- `read_data` while EMPTY is ignored.
- Gaps (`data_valid`=0) in the middle of a word are legal. The counter and partial assembly hold their values.
- Reset in the middle of a word discards the partial assembly and the held word. Realignment comes only from reset; the block has no in-band framing.

## Timing
- Reset values: `data_ready`=0, `data_out`=0, `overflow`=0, counter 0, assembly register 0, FSM IDLE.
- Latency: if the last segment is strobed in cycle N, `data_ready`=1 and `data_out` is valid in cycle N+1.
- Throughput: one word per num_segments cycles, sustained indefinitely if the consumer pops within num_segments cycles of `data_ready` rising.
- The pop takes effect at the edge ending the cycle in which `read_data`=1 and `data_ready`=1. `data_ready` falls in the next cycle unless a completion coincides.
- `data_out` changes only on a load. It does not change on a pop to EMPTY.
- All outputs are registered, with no combinational path from input to output.

## Structure
- Shared package `serdes_pkg` holds:
  - assembly state enum `IDLE`/`ASSEMBLE` (1 bit), shared with the serializer;
  - function `num_segments(in_w, out_w)`;
  - parameter-check helper.
- A single module. The output holding register is small enough to stay inline, so there is no sub-module.
- Elaboration-time assertion on the width constraint.

## Test plan
Bench parameters: in=32, out=128, so 4 segments.
- Reset then idle: `data_valid`=0 for 20 cycles → `data_ready`=0, `overflow`=0, `data_out`=0 throughout.
- Single word: segments 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles → one cycle after the last, `data_ready`=1, `data_out`=0x44444444_33333333_22222222_11111111; a `read_data` pulse drops `data_ready` the next cycle.
- Back-to-back stream with `read_data` tied to 1: 8 words continuous → 8 `data_ready` pulses 4 cycles apart, data in order, `overflow`=0.
- Mid-word gaps: 2 segments, 3 idle cycles, 2 segments → correct word, `data_ready` one cycle after the 4th segment.
- Overflow: 2 words streamed with no pop → first word retained in `data_out`, `overflow`=1 after the 2nd completion; `overflow` stays 1 after popping; a pop coinciding with a completion keeps `data_ready`=1 and loads the new word.
- Async reset asserted after 2 segments, between clock edges → outputs clear immediately; the next 4 segments form a correctly aligned word.
